// File: rtl/draw_text_overlay.sv
// draw_text_overlay
// Overlays a ROWS x COLS grid of CHAR_W x CHAR_H glyphs on a video stream
// whenever the game reports game-over or victory. The text can blink.
// All state changes happen on the rising edge of vsync, so a frame is never
// drawn half in one state and half in another.
//
// Ports
//   pclk, rst                      pixel clock, async active-low reset
//   hcount/vcount/*sync/*blnk_in   raster timing in
//   rgb_in                         upstream pixel
//   char_pixels                    font ROM line (MSB = leftmost pixel),
//                                  valid 2 cycles after char_yx/char_line
//   game_over, victory, blink_en   status levels
//   *_out                          timing delayed by 3 cycles
//   rgb_out                        composed pixel
//   char_yx, char_line             combinational ROM address (0 outside box)
//   overlay_on                     1 while glyphs are being shown
module draw_text_overlay #(
    parameter int          X_POS           = 232,
    parameter int          Y_POS           = 380,
    parameter int          COLS            = 14,
    parameter int          ROWS            = 6,
    parameter int          CHAR_W          = 40,
    parameter int          CHAR_H          = 40,
    parameter int          BLINK_FRAMES    = 30,
    parameter int          BOX_EN          = 0,
    parameter logic [11:0] GAME_OVER_COLOR = 12'hfaa,
    parameter logic [11:0] WIN_COLOR       = 12'hb9f,
    parameter logic [11:0] BOX_COLOR       = 12'h000
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [10:0]       hcount_in,
    input  logic [10:0]       vcount_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic [CHAR_W-1:0] char_pixels,
    input  logic              game_over,
    input  logic              victory,
    input  logic              blink_en,
    output logic [10:0]       hcount_out,
    output logic [10:0]       vcount_out,
    output logic              hsync_out,
    output logic              hblnk_out,
    output logic              vsync_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out,
    output logic [7:0]        char_yx,
    output logic [7:0]        char_line,
    output logic              overlay_on
);

    // Box edges are compared on 12 bits so X_POS + COLS*CHAR_W cannot overflow.
    localparam logic [11:0] X_LO    = 12'(X_POS);
    localparam logic [11:0] X_HI    = 12'(X_POS + COLS * CHAR_W);
    localparam logic [11:0] Y_LO    = 12'(Y_POS);
    localparam logic [11:0] Y_HI    = 12'(Y_POS + ROWS * CHAR_H);
    localparam logic [10:0] X0      = 11'(X_POS);
    localparam logic [10:0] Y0      = 11'(Y_POS);
    localparam logic [10:0] CW      = 11'(CHAR_W);
    localparam logic [10:0] CH      = 11'(CHAR_H);
    localparam logic [7:0]  BF_LAST = 8'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SHOW, HIDE} state_t;

    function automatic logic in_box(input logic [10:0] h, input logic [10:0] v);
        return ({1'b0, h} >= X_LO) && ({1'b0, h} < X_HI) &&
               ({1'b0, v} >= Y_LO) && ({1'b0, v} < Y_HI);
    endfunction

    // ---------------- stage 0: ROM address ----------------
    logic [10:0] w_xr0, w_yr0;
    logic        w_in0;

    assign w_xr0     = hcount_in - X0;
    assign w_yr0     = vcount_in - Y0;
    assign w_in0     = in_box(hcount_in, vcount_in);
    // Gated by rst so the address bus also reads 0 during reset.
    assign char_yx   = (rst && w_in0) ? {4'(w_yr0 / CH), 4'(w_xr0 / CW)} : 8'h00;
    assign char_line = (rst && w_in0) ? 8'(w_yr0 % CH) : 8'h00;

    // ---------------- timing pipeline (stages 1, 2) ----------------
    logic [10:0] r_h1, r_v1, r_h2, r_v2;
    logic [3:0]  r_s1, r_s2;      // {hsync, hblnk, vsync, vblnk}
    logic [11:0] r_rgb1, r_rgb2;

    // ---------------- frame FSM ----------------
    state_t     r_state, w_state_nx;
    logic [7:0] r_cnt, w_cnt_nx;
    logic       r_vic, w_vic_nx;  // latched mode: 1 = victory colour
    logic       r_vs_prev;
    logic       w_tick;

    assign w_tick     = vsync_in & ~r_vs_prev;
    assign overlay_on = (r_state == SHOW);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_vic_nx   = r_vic;
        if (w_tick) begin
            if (!game_over && !victory) begin
                // Clearing beats any blink transition.
                w_state_nx = IDLE;
                w_cnt_nx   = 8'd0;
            end else begin
                // game_over wins when both are set; re-latched every frame.
                w_vic_nx = ~game_over;
                if (r_state == IDLE) begin
                    w_state_nx = SHOW;
                    w_cnt_nx   = 8'd0;
                end else if (!blink_en) begin
                    w_state_nx = SHOW;
                    w_cnt_nx   = 8'd0;
                end else if (r_cnt == BF_LAST) begin
                    // BLINK_FRAMES-th tick of this phase: flip, restart count.
                    w_state_nx = (r_state == SHOW) ? HIDE : SHOW;
                    w_cnt_nx   = 8'd0;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
        end
    end

    // ---------------- stage 2: compose ----------------
    logic [10:0]       w_xr2, w_xm2;
    logic [CHAR_W-1:0] w_sh;
    logic              w_in2, w_glyph;
    logic [11:0]       w_rgb_nx;

    assign w_in2   = in_box(r_h2, r_v2);
    assign w_xr2   = r_h2 - X0;
    assign w_xm2   = w_xr2 % CW;
    // Shift the wanted glyph bit up into the MSB position.
    assign w_sh    = char_pixels << w_xm2;
    assign w_glyph = w_in2 & w_sh[CHAR_W-1];

    always_comb begin
        w_rgb_nx = r_rgb2;
        if (w_glyph && r_state == SHOW)
            w_rgb_nx = r_vic ? WIN_COLOR : GAME_OVER_COLOR;
        else if (w_in2 && BOX_EN != 0 && r_state != IDLE)
            w_rgb_nx = BOX_COLOR;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_h1       <= '0;
            r_v1       <= '0;
            r_s1       <= '0;
            r_rgb1     <= '0;
            r_h2       <= '0;
            r_v2       <= '0;
            r_s2       <= '0;
            r_rgb2     <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_vic      <= 1'b0;
            r_vs_prev  <= 1'b0;
        end else begin
            r_h1       <= hcount_in;
            r_v1       <= vcount_in;
            r_s1       <= {hsync_in, hblnk_in, vsync_in, vblnk_in};
            r_rgb1     <= rgb_in;
            r_h2       <= r_h1;
            r_v2       <= r_v1;
            r_s2       <= r_s1;
            r_rgb2     <= r_rgb1;
            hcount_out <= r_h2;
            vcount_out <= r_v2;
            {hsync_out, hblnk_out, vsync_out, vblnk_out} <= r_s2;
            rgb_out    <= w_rgb_nx;
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_vic      <= w_vic_nx;
            r_vs_prev  <= vsync_in;
        end
    end

endmodule

// File: tb/tb_draw_text_overlay.sv
// Directed bench for draw_text_overlay (defaults, BLINK_FRAMES = 2).
// A frame-level model runs alongside and is compared every cycle; literal
// checks in the main sequence pin the model's expectations.
module tb_draw_text_overlay;
    localparam int XP = 232, YP = 380, NC = 14, NR = 6, CW = 40, CH = 40, BF = 2;
    localparam logic [11:0] GOC = 12'hfaa, WINC = 12'hb9f;
    localparam logic [39:0] MSB    = 40'h80_0000_0000;
    localparam logic [39:0] NOTMSB = 40'h7f_ffff_ffff;

    logic        pclk = 1'b0, rst = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [39:0] char_pixels = '0;
    logic        game_over = 1'b0, victory = 1'b0, blink_en = 1'b0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [7:0]  char_yx, char_line;
    logic        overlay_on;

    always #5 pclk = ~pclk;

    draw_text_overlay #(.BLINK_FRAMES(BF)) dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixels(char_pixels),
        .game_over(game_over), .victory(victory), .blink_en(blink_en),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .char_yx(char_yx), .char_line(char_line), .overlay_on(overlay_on)
    );

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit inbox(input int h, input int v);
        return h >= XP && h < XP + NC * CW && v >= YP && v < YP + NR * CH;
    endfunction

    // ---------------- model + per-cycle compare ----------------
    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic [3:0]  s;
        logic [11:0] rgb;
    } px_t;

    px_t         hist [3];
    px_t         e_px;
    logic [11:0] e_rgb;
    int          m_state;   // 0 idle, 1 show, 2 hide
    int          m_cnt;
    bit          m_vic, m_vsp;

    initial begin
        px_t cur;
        int  xm, xr, yr;
        bit  g;
        logic [7:0] eyx, eln;
        m_state = 0; m_cnt = 0; m_vic = 0; m_vsp = 0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
        e_px = '0; e_rgb = '0;
        forever begin
            @(negedge pclk);
            if (!rst) begin
                m_state = 0; m_cnt = 0; m_vic = 0; m_vsp = 0;
                for (int i = 0; i < 3; i++) hist[i] = '0;
                e_px = '0; e_rgb = '0;
            end else begin
                // outputs produced by the last rising edge
                chk("rgb_out", 64'(rgb_out), 64'(e_rgb));
                chk("timing_out", 64'({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}),
                    64'({e_px.h, e_px.v, e_px.s}));
                chk("overlay_on", 64'(overlay_on), 64'(m_state == 1));
                eyx = 8'h00; eln = 8'h00;
                if (inbox(int'(hcount_in), int'(vcount_in))) begin
                    xr = int'(hcount_in) - XP;
                    yr = int'(vcount_in) - YP;
                    eyx = {4'(yr / CH), 4'(xr / CW)};
                    eln = 8'(yr % CH);
                end
                chk("char_yx", 64'(char_yx), 64'(eyx));
                chk("char_line", 64'(char_line), 64'(eln));

                // advance to what the next rising edge will produce
                cur.h = hcount_in; cur.v = vcount_in;
                cur.s = {hsync_in, hblnk_in, vsync_in, vblnk_in};
                cur.rgb = rgb_in;
                hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = cur;
                g = 1'b0;
                if (inbox(int'(hist[2].h), int'(hist[2].v))) begin
                    xm = (int'(hist[2].h) - XP) % CW;
                    g = char_pixels[CW-1-xm];
                end
                e_px  = hist[2];
                e_rgb = (g && m_state == 1) ? (m_vic ? WINC : GOC) : hist[2].rgb;
                if (vsync_in && !m_vsp) begin
                    if (!game_over && !victory) begin
                        m_state = 0; m_cnt = 0;
                    end else if (m_state == 0) begin
                        m_state = 1; m_cnt = 0; m_vic = !game_over;
                    end else begin
                        m_vic = !game_over;
                        if (!blink_en) begin
                            m_state = 1; m_cnt = 0;
                        end else begin
                            m_cnt++;
                            if (m_cnt == BF) begin
                                m_state = 3 - m_state; m_cnt = 0;
                            end
                        end
                    end
                end
                m_vsp = vsync_in;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pix(input int h, input int v, input logic vs, input logic [11:0] rgb, input logic [39:0] cp);
        @(posedge pclk);
        #2;
        hcount_in   = 11'(h);
        vcount_in   = 11'(v);
        hsync_in    = h[0];
        hblnk_in    = h[1];
        vblnk_in    = v[0];
        vsync_in    = vs;
        rgb_in      = rgb;
        char_pixels = cp;
    endtask

    task automatic tick_frame();
        pix(0, 0, 1'b1, 12'h0, '0);
        pix(1, 0, 1'b0, 12'h0, '0);
        #1;
    endtask

    // glyph pixel at the box origin; font line answered two cycles later
    task automatic glyph(input logic [39:0] cp, input logic [11:0] rgb, input logic [11:0] exp, input string nm);
        pix(232, 380, 1'b0, rgb, '0);
        pix(233, 380, 1'b0, 12'h0, '0);
        pix(234, 380, 1'b0, 12'h0, cp);
        pix(235, 380, 1'b0, 12'h0, '0);
        #1;
        chk(nm, 64'(rgb_out), 64'(exp));
    endtask

    int bl_exp [5] = '{1, 1, 0, 0, 1};

    initial begin
        // reset state
        hcount_in = 11'd312; vcount_in = 11'd420; rgb_in = 12'hfff;
        repeat (3) @(posedge pclk);
        #3;
        chk("rst_rgb", 64'(rgb_out), 64'h0);
        chk("rst_hout", 64'(hcount_out), 64'h0);
        chk("rst_yx", 64'(char_yx), 64'h0);
        chk("rst_ov", 64'(overlay_on), 64'h0);
        rst = 1'b1;

        // pipeline latency
        pix(0, 0, 1'b0, 12'h123, '0);
        pix(1, 0, 1'b0, 12'h000, '0);
        pix(2, 0, 1'b0, 12'h000, '0);
        pix(3, 0, 1'b0, 12'h000, '0);
        #1;
        chk("pipe_rgb", 64'(rgb_out), 64'h123);
        chk("pipe_hout", 64'(hcount_out), 64'h0);

        // address generation and box edges
        pix(312, 420, 1'b0, 12'h0, '0); #1;
        chk("addr_yx", 64'(char_yx), 64'h12);
        chk("addr_line", 64'(char_line), 64'h0);
        pix(271, 459, 1'b0, 12'h0, '0); #1;
        chk("addr_yx_b", 64'(char_yx), 64'h10);
        chk("addr_line_b", 64'(char_line), 64'd39);
        pix(791, 619, 1'b0, 12'h0, '0); #1;
        chk("addr_yx_last", 64'(char_yx), 64'h5d);
        pix(231, 380, 1'b0, 12'h0, '0); #1;
        chk("addr_left_out", 64'(char_yx), 64'h0);
        pix(792, 380, 1'b0, 12'h0, '0); #1;
        chk("addr_right_out", 64'(char_yx), 64'h0);

        // victory glyph colour
        victory = 1'b1;
        tick_frame();
        chk("vic_show", 64'(overlay_on), 64'h1);
        glyph(MSB, 12'h555, WINC, "glyph_on");
        glyph(NOTMSB, 12'h555, 12'h555, "glyph_off");

        // blink with BLINK_FRAMES = 2
        victory = 1'b0;
        tick_frame();
        chk("to_idle", 64'(overlay_on), 64'h0);
        game_over = 1'b1; blink_en = 1'b1;
        tick_frame();
        chk("blink_0", 64'(overlay_on), 64'(bl_exp[0]));
        for (int i = 1; i < 5; i++) begin
            tick_frame();
            chk($sformatf("blink_%0d", i), 64'(overlay_on), 64'(bl_exp[i]));
            if (i == 2) glyph(MSB, 12'h0a0, 12'h0a0, "hide_blank");
        end

        // priority, mid-frame drop, clear
        blink_en = 1'b0; victory = 1'b1;
        tick_frame();
        glyph(MSB, 12'h321, GOC, "prio_go");
        game_over = 1'b0; victory = 1'b0;
        glyph(MSB, 12'h321, GOC, "hold_midframe");
        tick_frame();
        chk("clear_idle", 64'(overlay_on), 64'h0);
        glyph(MSB, 12'h321, 12'h321, "idle_pass");

        // mode re-latched on frame boundary
        victory = 1'b1;
        tick_frame();
        glyph(MSB, 12'h321, WINC, "vic_mode");
        game_over = 1'b1;
        glyph(MSB, 12'h321, WINC, "mode_hold");
        tick_frame();
        glyph(MSB, 12'h321, GOC, "mode_switch");

        // async reset during SHOW
        glyph(MSB, 12'h777, GOC, "pre_rst");
        rst = 1'b0;
        #1;
        chk("arst_rgb", 64'(rgb_out), 64'h0);
        chk("arst_ov", 64'(overlay_on), 64'h0);
        repeat (3) @(posedge pclk);
        #4;
        rst = 1'b1;
        tick_frame();
        chk("rst_first_tick", 64'(overlay_on), 64'h1);
        glyph(MSB, 12'h456, GOC, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/draw_text_overlay.md
DRAW_TEXT_OVERLAY -- requirements
Module: draw_text_overlay

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- X_POS, 232: left edge of the text box in pixels.
- Y_POS, 380: top edge of the text box in pixels.
- COLS, 14: character columns, 1..16.
- ROWS, 6: character rows, 1..16.
- CHAR_W, 40: glyph width in pixels, 1..64.
- CHAR_H, 40: glyph height in pixels, 1..256.
- BLINK_FRAMES, 30: frames per blink phase, 1..255.
- BOX_EN, 0: 1 = fill non-glyph box pixels with BOX_COLOR.
- GAME_OVER_COLOR, 12'hfaa: glyph colour in game-over mode.
- WIN_COLOR, 12'hb9f: glyph colour in victory mode.
- BOX_COLOR, 12'h000: box background colour.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- pclk, in, 1: pixel clock; the only clock.
- rst, in, 1: reset, asynchronous, active-low.
- hcount_in / vcount_in, in, 11 each: timing counters.
- hsync_in, hblnk_in, vsync_in, vblnk_in, in, 1 each: timing strobes.
- rgb_in, in, 12: upstream pixel.
- char_pixels, in, CHAR_W: font ROM line, MSB = leftmost pixel.
- game_over, victory, in, 1 each: game status levels.
- blink_en, in, 1: enables blinking.
- hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, out: timing delayed 3 cycles.
- rgb_out, out, 12: composed pixel.
- char_yx, out, 8: {row[3:0], col[3:0]} address to the char ROM.
- char_line, out, 8: glyph line index to the font ROM.
- overlay_on, out, 1: 1 while state is SHOW.

Function
REQ-003 All timing outputs SHALL equal their inputs delayed by exactly 3 pclk cycles.
REQ-004 The stage-0 box-relative coordinates SHALL be xr = hcount_in - X_POS and yr = vcount_in - Y_POS, computed 11-bit unsigned.
REQ-005 Inside the box, char_yx SHALL be combinational from stage-0 inputs: {yr/CHAR_H, xr/CHAR_W}.
REQ-006 Inside the box, char_line SHALL be combinational from stage-0 inputs: yr mod CHAR_H.
REQ-007 Outside the box, char_yx and char_line SHALL both be 0.
REQ-008 The box SHALL be X_POS <= h < X_POS+COLS*CHAR_W and Y_POS <= v < Y_POS+ROWS*CHAR_H, evaluated on the delayed counters at stage 2.
REQ-009 char_pixels SHALL be treated as valid 2 cycles after the address it answers and sampled at stage 2.
REQ-010 The glyph bit SHALL be char_pixels[CHAR_W-1 - (xr2 mod CHAR_W)], where xr2 is the stage-2 delayed xr.
REQ-011 rgb_out priority SHALL be:
- glyph bit = 1 and state = SHOW: mode colour;
- else, inside the box with BOX_EN=1 and state ≠ IDLE: BOX_COLOR;
- else: rgb_in delayed 3 cycles.
REQ-012 frame_tick SHALL be a one-cycle pulse on the rising edge of vsync_in, detected with a registered previous value.
REQ-013 The FSM SHALL have three states: IDLE, SHOW, HIDE. It SHALL change state only on frame_tick, so there is no mid-frame tearing.
REQ-014 IDLE -> SHOW SHALL occur when game_over or victory is 1 at frame_tick. The mode SHALL be latched at that point, with game_over taking priority when both are 1.
REQ-015 From SHOW, when blink_en=1, the FSM SHALL count frame_ticks and go to HIDE on the BLINK_FRAMES-th tick. HIDE -> SHOW SHALL be symmetric. The frame counter SHALL clear on every transition.
REQ-016 With blink_en=0, the FSM SHALL stay in SHOW or return to SHOW from HIDE at the next tick. The counter SHALL be held at 0.
REQ-017 Any state SHALL go to IDLE at a frame_tick where game_over=0 and victory=0. This takes precedence over blink transitions.
REQ-018 The latched mode SHALL be re-evaluated at each frame_tick while not IDLE, so victory -> game_over switches colour on a frame boundary.
REQ-019 Frame counter width SHALL be 8 bits. It SHALL never wrap: it saturates at BLINK_FRAMES and then clears.

Reset
REQ-020 While rst=0, all pipeline registers and outputs SHALL be 0, the FSM SHALL be IDLE, the counter 0, the mode game_over, and the vsync history 0.
REQ-021 Reset assertion mid-frame SHALL take effect immediately. The first frame_tick after release SHALL be honoured.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Pipeline: rgb_in = 12'h123 at h=0, no status -> rgb_out = 12'h123 and hcount_out = 0 exactly 3 cycles later.
- Address: h=312, v=420 inside the box at defaults -> char_yx = 8'h12 and char_line = 0 in the same cycle.
- Glyph colour: victory=1, then a vsync rising edge; at h=232, v=380 with char_pixels[39]=1 -> rgb_out = 12'hb9f. With char_pixels[39]=0 -> rgb_out = delayed rgb_in.
- Blink: game_over=1, blink_en=1, BLINK_FRAMES=2 -> overlay_on follows 1,1,0,0,1 over 5 successive frames after the entry tick.
- Clear and priority: both status inputs 1 -> game_over colour 12'hfaa. Both dropped mid-frame -> glyph still drawn until the next vsync rising edge, then IDLE.
- Reset: assert rst=0 during SHOW -> rgb_out = 0 and overlay_on = 0 asynchronously. After release with game_over=1 -> SHOW at the first tick.
